// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline-stage register with a valid/ready handshake and a
// 2-entry skid buffer. It stands in for the classic fixed-field stage
// registers (IF/ID, ID/EX, EX/MEM, MEM/WB). The instantiating stage packs
// its control and data buses into in_ctrl / in_data.
//
// Design intent:
//   - in_ready is a pure function of flop state (!skid valid). Stall
//     back-pressure therefore never forms a combinational path from
//     out_ready back to in_ready.
//   - flush turns the stage into a bubble. All control bits zero is a NOP.
//   - Words leave in acceptance order. No word is duplicated or dropped,
//     except by flush or reset.
//
// Parameters:
//   CTRL_W              width of control field (all-zero = NOP)
//   DATA_W              width of data field
//   CLEAR_DATA_ON_FLUSH 1: data regs zeroed on flush, 0: data regs hold
//   CNT_W               width of saturating stall-cycle counter
//
// Ports:
//   clk        in   1       clock, all state on rising edge
//   reset      in   1       synchronous, active-high reset
//   flush      in   1       synchronous flush, discards both entries
//   in_valid   in   1       upstream offers a stage word
//   in_ready   out  1       stage can accept (registered: no skid word held)
//   in_ctrl    in   CTRL_W  upstream control field
//   in_data    in   DATA_W  upstream data field
//   out_valid  out  1       main entry holds a valid word
//   out_ready  in   1       downstream accepts (0 = hazard stall)
//   out_ctrl   out  CTRL_W  main control field, forced 0 when !out_valid
//   out_data   out  DATA_W  main data field
//   occupancy  out  2       entries held: 0, 1 or 2
//   stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 128,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Each state's encoding equals the number of entries it holds, so the
  // occupancy output is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main invalid, skid invalid
    ONE   = 2'd1,  // main valid
    TWO   = 2'd2   // main and skid valid
  } state_t;

  state_t              state;

  // Main entry drives the outputs. The skid entry catches the word that was
  // accepted in the same cycle the downstream stalled.
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic [DATA_W-1:0]   skid_data;

  logic                in_fire;
  logic                out_fire;
  logic                stalled;
  logic                stall_sat;

  // -------------------------------------------------------------------------
  // Handshake decode. in_ready and out_valid depend only on the state flop,
  // so neither handshake term feeds back into the other within a cycle.
  // -------------------------------------------------------------------------
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign occupancy = state;

  // Downstream sees a NOP whenever nothing valid is presented, even though
  // main_ctrl keeps its stale value after a drain.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  assign stalled   = out_valid & ~out_ready;
  assign stall_sat = (stall_cnt == {CNT_W{1'b1}});

  // -------------------------------------------------------------------------
  // Occupancy FSM and entry registers.
  //
  // Priority: reset > flush > handshakes. In a flush cycle both in_fire and
  // out_fire are void. The offered input word is dropped, and the word on
  // the output is treated as never delivered.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking (<=) everywhere in clocked blocks. Every flop
      // then samples pre-edge values, whatever order the statements run in.
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      // NOTE: the data registers are reset as well. out_data must read 0
      // after reset, so these are plain flops and must not be mapped to a
      // RAM macro that has no reset.
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      // Leaving the data regs untouched when clearing is disabled saves
      // toggling wide buses. The ctrl regs alone already make a bubble.
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end

        ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: the new word replaces the one leaving.
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            // Downstream stalled while upstream delivered. Park the word in
            // the skid entry. in_ready drops next cycle, one cycle late.
            state     <= TWO;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            state     <= EMPTY;
          end
        end

        TWO: begin
          // in_ready is 0 here, so only the drain of main is possible.
          if (out_fire) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall-cycle counter. Only reset clears it. It counts stall cycles
  // whether or not a flush is active, and it sticks at all-ones.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled && !stall_sat) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Embedded properties. Synthesis ignores concurrent assertions. They
  // document the contract for anyone editing the FSM.
  // -------------------------------------------------------------------------

  // Only the three defined encodings are reachable.
  a_state_legal: assert property (@(posedge clk) disable iff (reset)
    (state == EMPTY) || (state == ONE) || (state == TWO));

  // A stalled word must be held unchanged until it is taken.
  a_hold_on_stall: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush)
      |=> (out_valid && $stable(out_ctrl) && $stable(out_data)));

  // A flush always leaves a bubble behind.
  a_flush_bubble: assert property (@(posedge clk) disable iff (reset)
    flush |=> (!out_valid && (out_ctrl == '0)));

  // The saturating counter never wraps back to zero.
  a_stall_saturates: assert property (@(posedge clk) disable iff (reset)
    stall_sat |=> stall_sat);

  // With nothing valid, the control output must be a NOP.
  a_ctrl_gated: assert property (@(posedge clk) disable iff (reset)
    !out_valid |-> (out_ctrl == '0));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Scoreboard bench for pipe_stage_skid (CTRL_W=16, DATA_W=32, CNT_W=4,
// CLEAR_DATA_ON_FLUSH=1).
//
// Process roles:
//   - The stimulus process drives inputs 1 ns after each rising edge and
//     makes directed checks against hand-computed constants.
//   - The acceptance process runs on the rising edge. It pushes every word
//     the stage should accept into exp_q, and drops entries on flush/reset.
//   - The monitor runs on the falling edge. It compares whatever the DUT
//     presents against the front of exp_q, and compares stall_cnt against
//     the expected count.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int CTRL_W  = 16;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } word_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Scoreboard state
  word_t exp_q[$];
  int    exp_stall      = 0;
  bit    exp_data_zero  = 1'b1;  // out_data must read 0 (after reset/flush)
  int    exp_delivered  = 0;
  int    dut_delivered  = 0;
  bit    acc_in_fire;
  bit    acc_out_fire;

  int    n_checks = 0;
  int    n_errors = 0;

  pipe_stage_skid #(
    .CTRL_W              (CTRL_W),
    .DATA_W              (DATA_W),
    .CLEAR_DATA_ON_FLUSH (1'b1),
    .CNT_W               (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consume one clock edge with the currently driven inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Acceptance side: decide from the spec's handshake rules what the stage
  // takes in and lets out at this edge.
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      exp_q.delete();
      exp_stall     = 0;
      exp_data_zero = 1'b1;
    end else if (reset === 1'b0) begin
      acc_in_fire  = in_valid && (exp_q.size() < 2);
      acc_out_fire = (exp_q.size() > 0) && out_ready;
      if ((exp_q.size() > 0) && !out_ready && (exp_stall < CNT_MAX))
        exp_stall++;
      if (flush) begin
        exp_q.delete();
        exp_data_zero = 1'b1;
      end else begin
        if (acc_out_fire) begin
          void'(exp_q.pop_front());
          exp_delivered++;
        end
        if (acc_in_fire) begin
          exp_q.push_back('{ctrl: in_ctrl, data: in_data});
          exp_data_zero = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: compare what the DUT presents, half a cycle from the edge.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("occupancy", {62'd0, occupancy}, 64'(exp_q.size()));
      check("in_ready",  {63'd0, in_ready},  {63'd0, exp_q.size() < 2});
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        check("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
      end else begin
        check("out_ctrl_gated", 64'(out_ctrl), 64'd0);
        if (exp_data_zero)
          check("out_data_cleared", 64'(out_data), 64'd0);
      end
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (out_valid && out_ready && !flush)
        dut_delivered++;
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;

    // T1: reset for two cycles
    step();
    step();
    reset = 1'b0;
    check("t1_out_valid", {63'd0, out_valid}, 64'd0);
    check("t1_in_ready",  {63'd0, in_ready},  64'd1);
    check("t1_out_ctrl",  64'(out_ctrl),      64'd0);
    check("t1_occupancy", {62'd0, occupancy}, 64'd0);
    check("t1_stall_cnt", 64'(stall_cnt),     64'd0);

    // T2: streaming, each word visible one cycle after acceptance
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = CTRL_W'(i + 1);
      in_data  = DATA_W'(32'hA0 + i);
      step();
      check("t2_out_ctrl", 64'(out_ctrl),     64'(i + 1));
      check("t2_out_data", 64'(out_data),     64'(32'hA0 + i));
      check("t2_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("t2_drained", {62'd0, occupancy}, 64'd0);

    // T3: two words into a stalled stage, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0011;
    in_data   = 32'h11;
    step();
    in_ctrl   = 16'h0022;
    in_data   = 32'h22;
    step();
    in_valid  = 1'b0;
    check("t3_occupancy", {62'd0, occupancy}, 64'd2);
    check("t3_in_ready",  {63'd0, in_ready},  64'd0);
    check("t3_out_data",  64'(out_data),      64'h11);
    repeat (3) step();
    check("t3_hold_data", 64'(out_data),      64'h11);
    check("t3_stall_cnt", 64'(stall_cnt),     64'd4);
    out_ready = 1'b1;
    step();
    check("t3_second",    64'(out_data),      64'h22);
    check("t3_occ_one",   {62'd0, occupancy}, 64'd1);
    step();
    check("t3_empty",     {62'd0, occupancy}, 64'd0);
    check("t3_stall_fin", 64'(stall_cnt),     64'd4);

    // T4: flush while TWO, with a word offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0033;
    in_data   = 32'h33;
    step();
    in_ctrl   = 16'h0044;
    in_data   = 32'h44;
    step();
    check("t4_full", {62'd0, occupancy}, 64'd2);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_ctrl   = 16'h0055;
    in_data   = 32'h55;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("t4_occupancy", {62'd0, occupancy}, 64'd0);
    check("t4_out_valid", {63'd0, out_valid}, 64'd0);
    check("t4_out_ctrl",  64'(out_ctrl),      64'd0);
    check("t4_out_data",  64'(out_data),      64'd0);
    repeat (3) step();
    check("t4_no_ghost",  {63'd0, out_valid}, 64'd0);
    check("t4_stall_cnt", 64'(stall_cnt),     64'd5);

    // T5: reset on the same edge as in_fire and out_fire
    in_valid  = 1'b1;
    in_ctrl   = 16'hFFFF;
    in_data   = 32'hDEADBEEF;
    step();
    check("t5_loaded", {63'd0, out_valid}, 64'd1);
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    in_valid  = 1'b0;
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_in_ready",  {63'd0, in_ready},  64'd1);
    check("t5_out_ctrl",  64'(out_ctrl),      64'd0);
    check("t5_out_data",  64'(out_data),      64'd0);
    check("t5_occupancy", {62'd0, occupancy}, 64'd0);
    check("t5_stall_cnt", 64'(stall_cnt),     64'd0);

    // T6: 20 stalled cycles saturate a 4-bit counter at 15
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h0066;
    in_data   = 32'h66;
    step();
    in_valid  = 1'b0;
    repeat (20) step();
    check("t6_stall_sat", 64'(stall_cnt), 64'd15);
    check("t6_hold_data", 64'(out_data),  64'h66);
    out_ready = 1'b1;
    step();
    check("t6_drained", {62'd0, occupancy}, 64'd0);

    // Random traffic: clear the counter first so it is seen climbing again.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = flush ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_ctrl   = CTRL_W'($urandom);
      in_data   = DATA_W'($urandom);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rand_drained",   {62'd0, occupancy}, 64'd0);
    check("rand_delivered", 64'(dut_delivered), 64'(exp_delivered));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
